// File: rtl/wb_ps2.sv
// wb_ps2: PS/2 device-to-host receiver with RX FIFO and interrupt on a Wishbone slave port.
// Two registers: DATA (adr 0) pops the FIFO head, CTRL (adr 1) holds enables, sticky flags and fill count.
module wb_ps2 #(
   parameter int FILTER     = 8,
   parameter int TIMEOUT    = 50000,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        cyc_i,
   input  logic        stb_i,
   input  logic        we_i,
   input  logic        adr_i,
   input  logic [3:0]  sel_i,
   input  logic [31:0] dat_i,
   output logic        ack_o,
   output logic [31:0] dat_o,
   output logic        irq,
   input  logic        ps2_clk,
   input  logic        ps2_dat
);
   localparam int FW = $clog2(FILTER + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [FW-1:0] FMAX = FW'(FILTER - 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, PARITY, STOP} state_t;

   state_t          state, next;
   logic            clk_meta, clk_sync, dat_meta, dat_sync, clk_filt;
   logic [FW-1:0]   fcnt;
   logic            fall, timeout;
   logic [2:0]      bcnt;
   logic [7:0]      shreg;
   logic            par;
   logic [TW-1:0]   tcnt;
   logic            push, set_perr, set_ferr;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wptr, rptr;
   logic [CW-1:0]   count;
   logic [3:0]      cnt4;
   logic            full, empty, pop, wr_ok;
   logic            irq_en, rx_en, perr, ferr, ovf;
   logic            req, wr_ctrl;
   logic [31:0]     rdata;
   logic            unused_bits;

   // Filtered clock flips only once the synchronised pin has disagreed for FILTER samples.
   always_ff @(posedge clk_i)
      if (!rstn_i) begin
         clk_meta <= 1'b1;
         clk_sync <= 1'b1;
         dat_meta <= 1'b1;
         dat_sync <= 1'b1;
         clk_filt <= 1'b1;
         fcnt     <= '0;
      end else begin
         clk_meta <= ps2_clk;
         clk_sync <= clk_meta;
         dat_meta <= ps2_dat;
         dat_sync <= dat_meta;
         if (clk_sync == clk_filt)
            fcnt <= '0;
         else if (fcnt == FMAX) begin
            clk_filt <= clk_sync;
            fcnt     <= '0;
         end else
            fcnt <= fcnt + 1'b1;
      end

   assign fall    = clk_filt & ~clk_sync & (fcnt == FMAX);
   assign timeout = (state != IDLE) & ~fall & (tcnt == TMAX);

   always_ff @(posedge clk_i)
      if (!rstn_i) state <= IDLE;
      else         state <= next;

   always_comb begin
      next = state;
      if (!rx_en || timeout)
         next = IDLE;
      else if (fall)
         unique case (state)
            IDLE:   next = dat_sync ? IDLE : SHIFT;
            SHIFT:  next = (bcnt == 3'd7) ? PARITY : SHIFT;
            PARITY: next = STOP;
            STOP:   next = IDLE;
         endcase
   end

   always_comb begin
      push     = rx_en & fall & (state == STOP) & dat_sync & (^{shreg, par});
      set_perr = rx_en & fall & (state == STOP) & ~(^{shreg, par});
      set_ferr = rx_en & (timeout | (fall & (state == STOP) & ~dat_sync));
   end

   always_ff @(posedge clk_i)
      if (!rstn_i) begin
         bcnt  <= '0;
         shreg <= '0;
         par   <= 1'b0;
         tcnt  <= '0;
      end else begin
         tcnt <= (state == IDLE || fall) ? '0 : tcnt + 1'b1;
         if (fall && state == IDLE) bcnt <= '0;
         if (fall && state == SHIFT) begin
            shreg <= {dat_sync, shreg[7:1]};
            bcnt  <= bcnt + 1'b1;
         end
         if (fall && state == PARITY) par <= dat_sync;
      end

   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign full  = count == CW'(FIFO_DEPTH);
   assign empty = count == '0;
   assign req   = cyc_i & stb_i & ~ack_o;
   assign pop   = req & ~we_i & ~adr_i & ~empty;
   assign wr_ok = push & (~full | pop);

   always_ff @(posedge clk_i)
      if (wr_ok) mem[wptr] <= shreg;

   always_ff @(posedge clk_i)
      if (!rstn_i) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr_ok) wptr <= wptr + 1'b1;
         if (pop)   rptr <= rptr + 1'b1;
         count <= count + CW'(wr_ok) - CW'(pop);
      end

   assign cnt4    = 4'(count);
   assign wr_ctrl = req & we_i & adr_i & sel_i[0];
   assign rdata   = adr_i ? {20'b0, cnt4, 1'b0, ovf, ferr, perr, 2'b0, rx_en, irq_en}
                          : (empty ? 32'b0 : {23'b0, 1'b1, mem[rptr]});

   // Hardware set wins over a software clear landing in the same cycle.
   always_ff @(posedge clk_i)
      if (!rstn_i) begin
         ack_o  <= 1'b0;
         dat_o  <= '0;
         irq    <= 1'b0;
         irq_en <= 1'b0;
         rx_en  <= 1'b1;
         perr   <= 1'b0;
         ferr   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         ack_o <= req;
         dat_o <= (req & ~we_i) ? rdata : '0;
         if (wr_ctrl) {rx_en, irq_en} <= dat_i[1:0];
         perr <= set_perr | (perr & ~(wr_ctrl & dat_i[4]));
         ferr <= set_ferr | (ferr & ~(wr_ctrl & dat_i[5]));
         ovf  <= (push & full & ~pop) | (ovf & ~(wr_ctrl & dat_i[6]));
         irq  <= irq_en & (~empty | perr | ferr | ovf);
      end

   assign unused_bits = ^{sel_i[3:1], dat_i[31:7], dat_i[3:2]};
endmodule

// File: tb/tb_wb_ps2.sv
// tb_wb_ps2: directed frames over the PS/2 pins with hand-computed register readbacks.
module tb_wb_ps2;
   localparam int FILT = 8;
   localparam int TOUT = 1000;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, adr = 1'b0;
   logic [3:0]  sel = 4'hf;
   logic [31:0] wdat = '0;
   logic        ack, irq;
   logic [31:0] rdat;
   logic        ps2c = 1'b1, ps2d = 1'b1;
   logic [31:0] rd;
   int          total = 0, bad = 0;

   always #5 clk = ~clk;

   wb_ps2 #(.FILTER(FILT), .TIMEOUT(TOUT), .FIFO_DEPTH(8)) dut (
      .clk_i(clk), .rstn_i(rstn), .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr),
      .sel_i(sel), .dat_i(wdat), .ack_o(ack), .dat_o(rdat), .irq(irq),
      .ps2_clk(ps2c), .ps2_dat(ps2d)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
      end
   endtask

   // Returns #1 into the ack cycle with the read data captured.
   task automatic wb(input logic w, input logic a, input logic [31:0] d, output logic [31:0] q);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
      for (int k = 0; k < 8; k++) begin
         tick(1);
         if (ack === 1'b1) break;
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      total++;
      assert (ack === 1'b1) else begin
         bad++;
         $error("FAIL ack_timeout obs=%b exp=1", ack);
      end
      q = rdat;
   endtask

   task automatic rd_chk(input logic a, input logic [31:0] exp, input string tag);
      logic [31:0] q;
      wb(1'b0, a, '0, q);
      chk(tag, q, exp);
   endtask

   task automatic wr(input logic a, input logic [31:0] d);
      logic [31:0] q;
      wb(1'b1, a, d, q);
   endtask

   // 60-cycle bit period; clock falls 15 cycles after data is set.
   task automatic send_bit(input logic b);
      ps2d = b;
      tick(15);
      ps2c = 1'b0;
      tick(30);
      ps2c = 1'b1;
      tick(15);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic bad_par);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit((~^d) ^ bad_par);
      send_bit(1'b1);
   endtask

   initial begin
      tick(3);
      chk("rst_ack", ack, 0);
      chk("rst_dat_o", rdat, 0);
      chk("rst_irq", irq, 0);
      rstn = 1'b1;
      tick(1);
      rd_chk(1'b1, 32'h002, "ctrl_reset");
      rd_chk(1'b0, 32'h000, "data_empty_reset");
      tick(1);
      chk("ack_one_cycle", ack, 0);
      chk("dat_o_idle", rdat, 0);

      send_frame(8'h1C, 1'b0);
      rd_chk(1'b1, 32'h102, "ctrl_cnt1");
      rd_chk(1'b0, 32'h11C, "data_1c");
      rd_chk(1'b0, 32'h000, "data_empty");

      send_frame(8'h1C, 1'b1);
      rd_chk(1'b1, 32'h012, "ctrl_perr");
      wr(1'b1, 32'h12);
      rd_chk(1'b1, 32'h002, "ctrl_perr_clr");

      for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0);
      rd_chk(1'b1, 32'h842, "ctrl_full_ovf");
      for (int i = 1; i <= 8; i++) rd_chk(1'b0, 32'h100 | 32'(i), "data_fifo");
      rd_chk(1'b0, 32'h000, "data_9th_empty");
      wr(1'b1, 32'h42);
      rd_chk(1'b1, 32'h002, "ctrl_ovf_clr");

      // Last falling pin edge is 45 cycles back; sampling follows it by 2+FILT cycles.
      wr(1'b1, 32'h03);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      tick(TOUT + 2 + FILT - 45);
      chk("irq_before_timeout", irq, 0);
      tick(1);
      chk("irq_after_timeout", irq, 1);
      rd_chk(1'b1, 32'h023, "ctrl_ferr");
      wr(1'b1, 32'h23);
      send_frame(8'hAA, 1'b0);
      rd_chk(1'b1, 32'h103, "ctrl_aa");
      rd_chk(1'b0, 32'h1AA, "data_aa");

      for (int i = 0; i < 3; i++) begin
         ps2c = 1'b0;
         tick(3);
         ps2c = 1'b1;
         tick(20);
      end
      rd_chk(1'b1, 32'h003, "ctrl_glitch");
      tick(2);
      chk("irq_idle", irq, 0);
      send_frame(8'h5A, 1'b0);
      tick(2);
      chk("irq_queued", irq, 1);
      wb(1'b0, 1'b0, '0, rd);
      chk("data_5a", rd, 32'h15A);
      chk("irq_ack_cycle", irq, 1);
      tick(1);
      chk("irq_drop", irq, 0);

      wr(1'b1, 32'h01);
      send_frame(8'h77, 1'b0);
      rd_chk(1'b1, 32'h001, "ctrl_rx_dis");
      wr(1'b1, 32'h03);
      wr(1'b0, 32'h55);
      rd_chk(1'b0, 32'h000, "data_write_ignored");

      send_frame(8'h11, 1'b0);
      tick(2);
      chk("irq_before_reset", irq, 1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      rstn = 1'b0;
      tick(1);
      rstn = 1'b1;
      chk("irq_after_reset", irq, 0);
      rd_chk(1'b1, 32'h002, "ctrl_after_reset");
      rd_chk(1'b0, 32'h000, "data_after_reset");
      send_frame(8'h3C, 1'b0);
      rd_chk(1'b1, 32'h102, "ctrl_post_reset_frame");
      rd_chk(1'b0, 32'h13C, "data_3c");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/wb_ps2.md
# wb_ps2

PS/2 keyboard/mouse receiver on the peripheral Wishbone bus, on a free slot of the 16-slave peripheral arbiter. Deglitches the PS/2 clock line, deserialises 11-bit device-to-host frames, checks start, parity and stop, and queues bytes in a small FIFO. The CPU reads the FIFO over a 2-register interface; an interrupt output feeds the interrupt controller's `irq_in` vector.

## Interface
- `FILTER`, 8: consecutive equal samples required before a PS/2 clock level change is accepted.
- `TIMEOUT`, 50000: `clk_i` cycles allowed between falling edges inside a frame.
- `FIFO_DEPTH`, 8: RX FIFO entries; power of two, at least 2.
- `clk_i` in 1: system clock; all logic is in this domain.
- `rstn_i` in 1: reset, synchronous, active-low.
- `cyc_i` in 1: Wishbone cycle.
- `stb_i` in 1: Wishbone strobe, from the arbiter slot.
- `we_i` in 1: write enable.
- `adr_i` in 1: word address; 0 = DATA, 1 = CTRL.
- `sel_i` in 4: byte selects; only `sel_i[0]` (`dat_i[7:0]`) is used.
- `dat_i` in 32: write data.
- `ack_o` out 1: Wishbone acknowledge.
- `dat_o` out 32: read data.
- `irq` out 1: level interrupt, active-high.
- `ps2_clk` in 1: asynchronous PS/2 clock pin.
- `ps2_dat` in 1: asynchronous PS/2 data pin.

## Operation
- **Input path:**
  - Both pins pass through 2-FF synchronisers.
  - The filtered clock changes only after `FILTER` consecutive samples at the new level.
  - A falling edge of the filtered clock samples the synchronised data.
- **Receive FSM states:** IDLE, SHIFT, PARITY, STOP.
  - IDLE: a falling edge with data=0 (start bit) enters SHIFT with bit count 0. Data=1 stays in IDLE and sets no error.
  - SHIFT: 8 edges, shifted LSB first, then PARITY.
  - PARITY: captures the parity bit, then STOP.
  - STOP: on the edge, the frame is good if stop=1 and the XOR of the 8 data bits and parity equals 1 (odd parity).
  - Good frame: push the byte. Parity failure sets `perr`. Stop=0 sets `ferr`. Return to IDLE either way; a bad frame is not pushed.
- **Timeout:** any non-IDLE state with no falling edge for `TIMEOUT` cycles sets `ferr` and returns to IDLE.
- **rx_en:** `rx_en`=0 forces IDLE and blocks pushes. The synchronisers keep running.
- **FIFO:** circular buffer with a count of width clog2(`FIFO_DEPTH`)+1.
  - A push when full drops the byte and sets `ovf`.
  - A push and pop in the same cycle leave the count unchanged and both take effect, including when full.
- **DATA (adr 0):**
  - Read returns {23'b0, valid, byte}. When the FIFO is non-empty, valid=1 with the head byte, and the entry is popped on the ack cycle.
  - Empty read returns 0 and does not pop.
  - Writes are acked and ignored.
- **CTRL (adr 1):**
  - Read returns {20'b0, count[3:0], 1'b0, ovf, ferr, perr, 2'b0, rx_en, irq_en}, i.e. bit0 irq_en, bit1 rx_en, bit4 perr, bit5 ferr, bit6 ovf, bits 11:8 count.
  - Write with `sel_i[0]`=1: bits 1:0 load irq_en and rx_en; a 1 in bits 6:4 clears the matching flag.
  - If a flag is cleared and set by hardware in the same cycle, the set wins.
- **irq:** registered, equal to irq_en & (count≠0 | perr | ferr | ovf).

## Timing
- **Reset values:**
  - Outputs: `ack_o`=0, `dat_o`=0, `irq`=0.
  - Control and flags: irq_en=0, rx_en=1, perr=ferr=ovf=0.
  - FIFO and FSM: FIFO empty, FSM in IDLE.
  - Synchroniser and filter: synchronisers and filtered clock preset to 1.
- **Reset mid-frame:** the partial byte is discarded; no flag is set.
- **Wishbone access:**
  - `ack_o` rises in the cycle after `cyc_i & stb_i & !ack_o` and stays high exactly 1 cycle. Back-to-back strobes get ack every other cycle.
  - `dat_o` is valid in the ack cycle and is 0 in every other cycle.
  - Pop and CTRL write side effects happen in the ack cycle.
- **Pin-to-FIFO latency:** 2 (sync) + `FILTER` cycles from a pin falling edge to the sampling edge. The push takes effect in the cycle after the STOP sampling edge.
- **irq latency:** `irq` follows its condition by 1 cycle. Popping the last entry with no flags drops `irq` in the cycle after the ack cycle.

## Test plan
- Frame 0x1C (start 0, data LSB first, parity 0, stop 1) at a 60-cycle bit period with `FILTER`=8, `TIMEOUT`=1000 -> CTRL count=1, DATA read returns 0x11C, then a DATA read returns 0x000.
- Same frame with parity=1 -> FIFO empty, CTRL bit4 set. Write CTRL 0x12 -> bit4 clears, rx_en stays 1.
- 9 good frames 0x01..0x09 with `FIFO_DEPTH`=8 -> count=8, ovf=1, reads return 0x101..0x108 in order, the 9th read returns 0.
- Stop clocking after 4 data bits -> ferr=1 exactly `TIMEOUT` cycles after the last edge. A following full frame 0xAA is received correctly.
- 3-cycle glitches on `ps2_clk` during IDLE -> no state change, no flags. With irq_en=1 and one byte queued, `irq`=1; the pop drops `irq` one cycle after the ack.
- `rstn_i` pulsed low in the middle of a frame -> all registers return to reset values, the FIFO is empty, and the next full frame is received.
